// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// tpu_pkg : widths, minifloat field positions and shared types for the
//           minifloat MAC operand feeder.
// Revision: 1.0
// ============================================================================
package tpu_pkg;

    localparam int MF_W   = 8;
    localparam int ACC_W  = 32;
    localparam int HALF_W = 16;

    // Minifloat layout: sign[7], exponent[6:3], mantissa[2:0]
    localparam int MF_SIGN_BIT = 7;
    localparam int MF_EXP_MSB  = 6;
    localparam int MF_EXP_LSB  = 3;
    localparam int MF_MAN_MSB  = 2;
    localparam int MF_MAN_LSB  = 0;

    typedef struct packed {
        logic [MF_W-1:0] a;
        logic [MF_W-1:0] b;
        logic            last;
    } mf_pair_t;

    localparam int PAIR_W = $bits(mf_pair_t);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_READ_HI = 3'd5,
        ST_READ_LO = 3'd6,
        ST_RESULT  = 3'd7
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_pair_fifo.sv
`default_nettype none
// ============================================================================
// mac_pair_fifo : synchronous FIFO with registered full/empty flags.
// Revision: 1.0
// ============================================================================
module mac_pair_fifo
    import tpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PAIR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_i & ~full_q;
    assign w_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// mac_operand_feeder : buffers minifloat operand pairs, sequences the MAC one
//                      pair at a time and reads back the 32-bit accumulator.
// Revision: 1.0
// ============================================================================
module mac_operand_feeder
    import tpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MF_W-1:0]   in_a,
    input  logic [MF_W-1:0]   in_b,
    input  logic              in_last,
    output logic              mac_clear,
    output logic              mac_sync,
    output logic [MF_W-1:0]   mac_in1,
    output logic [MF_W-1:0]   mac_in2,
    input  logic              mac_ready,
    input  logic              mac_error,
    output logic              mac_out_hl,
    input  logic [HALF_W-1:0] mac_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_error,
    output logic [LEN_W-1:0]  res_count
);

    mf_pair_t         w_fifo_wdata;
    mf_pair_t         w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_cnt_sat;

    feeder_state_t    state_q;
    feeder_state_t    state_d;
    logic [MF_W-1:0]  a_q;
    logic [MF_W-1:0]  a_d;
    logic [MF_W-1:0]  b_q;
    logic [MF_W-1:0]  b_d;
    logic             last_q;
    logic             last_d;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic             err_q;
    logic             err_d;
    logic [ACC_W-1:0] data_q;
    logic [ACC_W-1:0] data_d;

    assign in_ready     = ~w_fifo_full;
    assign w_fifo_push  = in_valid & ~w_fifo_full;
    assign w_fifo_wdata = '{a: in_a, b: in_b, last: in_last};
    assign w_fifo_pop   = (state_q == ST_FETCH) & ~w_fifo_empty;
    assign w_cnt_sat    = &count_q;

    mac_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_fifo_push),
        .wdata_i (w_fifo_wdata),
        .pop_i   (w_fifo_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                count_d = '0;
                err_d   = 1'b0;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!w_fifo_empty) begin
                    a_d     = w_fifo_rdata.a;
                    b_d     = w_fifo_rdata.b;
                    last_d  = w_fifo_rdata.last;
                    count_d = count_q + LEN_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A saturated count without 'last' forces readout and flags it
                if (mac_ready) begin
                    err_d = err_q | mac_error;
                    if (last_q) begin
                        state_d = ST_READ_HI;
                    end else if (w_cnt_sat) begin
                        err_d   = 1'b1;
                        state_d = ST_READ_HI;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_READ_HI: begin
                data_d[ACC_W-1:HALF_W] = mac_out;
                state_d                = ST_READ_LO;
            end
            ST_READ_LO: begin
                data_d[HALF_W-1:0] = mac_out;
                state_d            = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign mac_clear  = (state_q == ST_CLEAR);
    assign mac_sync   = (state_q == ST_ISSUE);
    assign mac_out_hl = (state_q == ST_READ_HI);
    assign mac_in1    = a_q;
    assign mac_in2    = b_q;
    assign res_valid  = (state_q == ST_RESULT);
    assign res_data   = data_q;
    assign res_error  = err_q;
    assign res_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// tb_mac_operand_feeder : scoreboard bench driving the feeder against a
//                         behavioural minifloat MAC.
// Revision: 1.0
// ============================================================================
module tb_mac_operand_feeder;
    import tpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int LEN_W = 4;
    localparam int MAXC  = (1 << LEN_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid;
    logic              in_ready;
    logic [MF_W-1:0]   in_a;
    logic [MF_W-1:0]   in_b;
    logic              in_last;
    logic              mac_clear;
    logic              mac_sync;
    logic [MF_W-1:0]   mac_in1;
    logic [MF_W-1:0]   mac_in2;
    logic              mac_ready;
    logic              mac_error;
    logic              mac_out_hl;
    logic [HALF_W-1:0] mac_out;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              res_error;
    logic [LEN_W-1:0]  res_count;

    mac_operand_feeder #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .mac_clear  (mac_clear),
        .mac_sync   (mac_sync),
        .mac_in1    (mac_in1),
        .mac_in2    (mac_in2),
        .mac_ready  (mac_ready),
        .mac_error  (mac_error),
        .mac_out_hl (mac_out_hl),
        .mac_out    (mac_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_error  (res_error),
        .res_count  (res_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Minifloat product: (1.m_a * 1.m_b) * 2^(e_a + e_b) scaled so 8'h08*8'h08 = 16
    function automatic longint mf_mag(input logic [7:0] x, input logic [7:0] y);
        longint m;
        int     e;
        if (x[MF_EXP_MSB:MF_EXP_LSB] == 4'd0 || y[MF_EXP_MSB:MF_EXP_LSB] == 4'd0) return 0;
        e = int'(x[MF_EXP_MSB:MF_EXP_LSB]) + int'(y[MF_EXP_MSB:MF_EXP_LSB]);
        m = longint'({1'b1, x[MF_MAN_MSB:MF_MAN_LSB]}) * longint'({1'b1, y[MF_MAN_MSB:MF_MAN_LSB]});
        return (m << e) >> 4;
    endfunction

    function automatic logic mf_ovf(input logic [7:0] x, input logic [7:0] y);
        return mf_mag(x, y) > 64'sd2147483647;
    endfunction

    function automatic logic [31:0] mf_val(input logic [7:0] x, input logic [7:0] y);
        longint    mag;
        logic [31:0] v;
        mag = mf_mag(x, y);
        v   = mag[31:0];
        return (x[MF_SIGN_BIT] ^ y[MF_SIGN_BIT]) ? (32'd0 - v) : v;
    endfunction

    // Behavioural MAC: accumulates on sync, readback through out_HL
    logic [31:0] mac_acc = '0;
    logic        mac_err_q = 1'b0;
    logic        mac_ready_en = 1'b1;

    always @(posedge clk) begin
        if (mac_clear) begin
            mac_acc   <= '0;
            mac_err_q <= 1'b0;
        end else if (mac_sync) begin
            mac_acc   <= mac_acc + mf_val(mac_in1, mac_in2);
            mac_err_q <= mf_ovf(mac_in1, mac_in2);
        end
    end

    assign mac_ready = mac_ready_en;
    assign mac_error = mac_err_q;
    assign mac_out   = mac_out_hl ? mac_acc[31:16] : mac_acc[15:0];

    typedef struct {
        logic [31:0]      data;
        logic             err;
        logic [LEN_W-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_acc;
    logic        m_err;
    int          m_cnt;

    task automatic model_reset();
        m_acc = '0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_push(input logic [7:0] a, input logic [7:0] b, input logic last);
        m_acc = m_acc + mf_val(a, b);
        m_err = m_err | mf_ovf(a, b);
        m_cnt++;
        if (last || m_cnt == MAXC) begin
            if (!last) m_err = 1'b1;
            sb.push_back('{m_acc, m_err, LEN_W'(m_cnt)});
            model_reset();
        end
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        int g = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            check("push_timeout", in_ready, 1);
        end else begin
            @(posedge clk); #1;
            model_push(a, b, last);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int g = 0;
        while (sb.size() != 0 && g < budget) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_pending", 32'(sb.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  in_ready,   1);
        check({tag, "_mac_clear"}, mac_clear,  0);
        check({tag, "_mac_sync"},  mac_sync,   0);
        check({tag, "_out_hl"},    mac_out_hl, 0);
        check({tag, "_mac_in1"},   mac_in1,    0);
        check({tag, "_mac_in2"},   mac_in2,    0);
        check({tag, "_res_valid"}, res_valid,  0);
        check({tag, "_res_data"},  res_data,   0);
        check({tag, "_res_error"}, res_error,  0);
        check({tag, "_res_count"}, res_count,  0);
    endtask

    // Monitor: scoreboard compare, result hold stability, sync/clear rules
    int               clear_cnt = 0;
    int               sync_cnt = 0;
    logic             prev_sync = 1'b0;
    logic             prev_hold = 1'b0;
    logic [31:0]      hold_data;
    logic             hold_err;
    logic [LEN_W-1:0] hold_cnt;
    exp_t             e;

    always @(negedge clk) begin
        if (reset) begin
            prev_sync = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (mac_clear) clear_cnt++;
            if (mac_sync) begin
                sync_cnt++;
                check("sync_back_to_back", prev_sync, 0);
                check("sync_with_clear", mac_clear, 0);
            end
            prev_sync = mac_sync;
            if (prev_hold) begin
                check("hold_valid", res_valid, 1);
                check("hold_data",  res_data,  hold_data);
                check("hold_error", res_error, hold_err);
                check("hold_count", res_count, hold_cnt);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("res_data",  res_data,  e.data);
                    check("res_error", res_error, e.err);
                    check("res_count", res_count, e.cnt);
                end
            end
            prev_hold = res_valid && !res_ready;
            hold_data = res_data;
            hold_err  = res_error;
            hold_cnt  = res_count;
        end
    end

    int lat;
    int first_block;
    int n;
    int g;

    initial begin
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_last      = 1'b0;
        res_ready    = 1'b1;
        mac_ready_en = 1'b1;
        reset        = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Single pair: latency, one clear, one sync, result 16
        clear_cnt = 0;
        sync_cnt  = 0;
        push_pair(8'h08, 8'h08, 1'b1);
        lat = 1;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 8);
        drain(100);
        check("single_clears", clear_cnt, 1);
        check("single_syncs", sync_cnt, 1);

        // Two-pair cancel to zero, then a fresh negative single
        clear_cnt = 0;
        push_pair(8'h08, 8'h08, 1'b0);
        push_pair(8'h88, 8'h08, 1'b1);
        push_pair(8'h88, 8'h08, 1'b1);
        drain(200);
        check("two_products_clears", clear_cnt, 2);

        // Exponent overflow in the MAC
        push_pair(8'h78, 8'h78, 1'b1);
        drain(100);

        // Back-to-back burst with the MAC stalled
        mac_ready_en = 1'b0;
        first_block  = -1;
        fork
            begin
                repeat (10) @(posedge clk);
                #1;
                mac_ready_en = 1'b1;
            end
            begin
                for (int i = 0; i < DEPTH + 2; i++) begin
                    if (!in_ready && first_block < 0) first_block = i;
                    push_pair({1'b0, 4'(i + 1), 3'(i)}, (i % 2 == 1) ? 8'h88 : 8'h08,
                              i == DEPTH + 1);
                end
            end
        join
        // One pair already sits in the operand registers when the FIFO fills
        check("burst_accepted_before_full", first_block, DEPTH + 1);
        drain(400);

        // Result held with res_ready low while the FIFO fills behind it
        res_ready = 1'b0;
        push_pair(8'h10, 8'h18, 1'b1);
        g = 0;
        while (!res_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("hold_reach_result", res_valid, 1);
        fork
            begin
                repeat (20) @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
            begin
                for (int i = 0; i < DEPTH; i++)
                    push_pair(8'h08 + 8'(i), 8'h10, i == DEPTH - 1);
                check("hold_full_after_depth", in_ready, 0);
            end
        join
        drain(400);

        // Length overflow: MAXC+2 pairs, only the last one tagged
        for (int i = 0; i < MAXC + 2; i++)
            push_pair(8'h08, 8'h08, i == MAXC + 1);
        drain(600);

        // Reset during WAIT of the third pair
        for (int i = 0; i < 4; i++) push_pair(8'h10, 8'h08, 1'b0);
        n = 0;
        g = 0;
        while (n < 3 && g < 200) begin
            @(negedge clk);
            if (mac_sync) n++;
            g++;
        end
        check("third_issue_seen", n, 3);
        mac_ready_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midreset");
        sb.delete();
        model_reset();
        reset        = 1'b0;
        mac_ready_en = 1'b1;
        clear_cnt    = 0;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_fifo_empty", clear_cnt, 0);
        check("midreset_no_result", res_valid, 0);
        push_pair(8'h08, 8'h08, 1'b1);
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach its end, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
